button_press_decoder: RTL and testbench
=======================================

# button_press_decoder

Classifies presses of an already-debounced push-button level into single-cycle events: short press (on release), long press (on hold threshold) and auto-repeat (periodic while held after a long press). It sits directly downstream of `debounce`: `debounced_button` feeds this block, and its pulses drive the FSMs and counters of the lab circuits. It is the consumer end of the debounced-button interface.

## Interface
- LONG_TIME, 2500: hold length in clock cycles for a long press (0.5 s at 5 kHz); must be ≥ 2.
- REPEAT_TIME, 500: repeat period in clock cycles while long-held (0.1 s at 5 kHz); must be ≥ 1.
- REPEAT_EN, 1: 1 enables `repeat_press`; 0 ties it to 0.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- debounced_button  in  1  clean, clk-synchronous button level; 1 = pressed.
- short_press  out  1  one-cycle pulse: released before the long threshold.
- long_press  out  1  one-cycle pulse: long threshold reached.
- repeat_press  out  1  one-cycle pulse every REPEAT_TIME cycles after long_press.
- held  out  1  level; 1 while FSM is not IDLE.

## Operation
- Internal counter `cnt`, width $clog2(max(LONG_TIME, REPEAT_TIME)+1). Saturation is never reached by design.
- Three states: IDLE, PRESSED, LONG_HELD.
- IDLE: cnt = 0. Button sampled 1 → PRESSED, cnt ← 1.
- PRESSED:
  - Button sampled 0 → IDLE, short_press ← 1.
  - Otherwise, if cnt == LONG_TIME → LONG_HELD, long_press ← 1, cnt ← 1.
  - Otherwise cnt ← cnt + 1.
- LONG_HELD:
  - Button sampled 0 → IDLE, no pulse.
  - Otherwise, if cnt == REPEAT_TIME → repeat_press ← REPEAT_EN, cnt ← 1.
  - Otherwise cnt ← cnt + 1.
- Every pulse output is registered and defaults to 0 on every edge where it is not set. No two pulses are ever high in the same cycle.
- held is registered: 1 in PRESSED and LONG_HELD.
- Priority: release beats threshold. Release on the same edge that cnt == LONG_TIME gives short_press, not long_press. Release on the same edge that cnt == REPEAT_TIME gives no repeat.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, cnt 0, short_press/long_press/repeat_press/held all 0, immediately, without waiting for a clock edge.
- Reset mid-press: the press is discarded and no pulse is issued. After rst returns to 1, a button still at 1 is treated as a new press from the next edge.
- Let E0 be the first edge sampling button = 1 in IDLE.
  - held rises after E0.
  - long_press is high for the cycle after E_LONG_TIME. This requires samples of 1 on E0..E_LONG_TIME inclusive.
  - Repeat pulses follow after E_(LONG_TIME + k·REPEAT_TIME), for k ≥ 1, while still held.
- A release sampled at E_k (1 ≤ k ≤ LONG_TIME) gives short_press and held = 0 in the cycle after E_k.
- A minimum press (button high for one sample) gives short_press exactly 1 cycle after the release edge.
- A re-press on the edge right after a release is accepted (IDLE → PRESSED). There is no dead time.
- Latency: all outputs change only on the clock edge following the causing sample, except under reset.

## Structure
- Shared header `button_defs.vh`:
  - state encoding localparams: S_IDLE = 2'd0, S_PRESSED = 2'd1, S_LONG_HELD = 2'd2;
  - default timing constants derived from CLOCK_FREQ = 5000.
  - Unused encoding 2'd3 returns to IDLE with all pulses 0.
- One sub-module, `press_timer`: a load-to-1 / increment counter with a terminal-compare output (`hit` when cnt == limit). It is parameterised by width and shares clk/rst. The FSM selects the limit: LONG_TIME in PRESSED, REPEAT_TIME in LONG_HELD.

## Test plan
Bench uses LONG_TIME = 10, REPEAT_TIME = 4, clock period 2.
- Reset asserted with button = 1, then released → all outputs 0 during reset; held = 1 after the first edge; no pulse yet.
- Press for 3 samples, then release → exactly one short_press, 1 cycle after the release edge; long_press and repeat_press never asserted.
- Hold for 20 samples → long_press after E10; repeat_press after E14 and E18; release → held = 0, no further pulses.
- Release exactly at E10 → short_press only; long_press stays 0.
- REPEAT_EN = 0, hold for 30 samples → one long_press; repeat_press stays 0.
- Assert rst during LONG_HELD → outputs 0 immediately; no pulse on release; the next press counts from 1 again.

Source files
------------

// File: rtl/button_press_decoder_pkg.sv
// Shared state encoding and default timing constants for the button press decoder.
`timescale 1ns/100ps
package button_press_decoder_pkg;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_PRESSED   = 2'd1;
   localparam logic [1:0] S_LONG_HELD = 2'd2;

   localparam int CLOCK_FREQ        = 32'sd5000;
   localparam int DEF_LONG_TIME     = CLOCK_FREQ / 32'sd2;
   localparam int DEF_REPEAT_TIME   = CLOCK_FREQ / 32'sd10;

   // Counter must hold the larger of the two thresholds.
   function automatic int cnt_width(input int long_time, input int repeat_time);
      int max_v;
      if (long_time > repeat_time) begin
         max_v = long_time;
      end else begin
         max_v = repeat_time;
      end
      return $clog2(max_v + 32'sd1);
   endfunction

endpackage

// File: rtl/button_press_decoder_press_timer.sv
// Load-to-1 / increment counter with terminal compare against a selectable limit.
`timescale 1ns/100ps
module press_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] limit,
   output logic         hit
);

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = W'(0);

   logic [W-1:0] cnt_r;

   // Counter: clear wins over load, otherwise count up by one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= ZERO;
      end else if (clr) begin
         cnt_r <= ZERO;
      end else if (load) begin
         cnt_r <= ONE;
      end else begin
         cnt_r <= cnt_r + ONE;
      end
   end

   assign hit = (cnt_r == limit);

endmodule

// File: rtl/button_press_decoder.sv
// Classifies a debounced button level into short, long and auto-repeat press pulses.
`timescale 1ns/100ps
module button_press_decoder
   import button_press_decoder_pkg::*;
#(
   parameter int LONG_TIME   = DEF_LONG_TIME,
   parameter int REPEAT_TIME = DEF_REPEAT_TIME,
   parameter bit REPEAT_EN   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic debounced_button,
   output logic short_press,
   output logic long_press,
   output logic repeat_press,
   output logic held
);

   localparam int CNT_W = cnt_width(LONG_TIME, REPEAT_TIME);
   localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_TIME);
   localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_TIME);

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic             short_nxt_s;
   logic             long_nxt_s;
   logic             repeat_nxt_s;
   logic             clr_s;
   logic             load_s;
   logic             hit_s;
   logic [CNT_W-1:0] limit_s;
   logic             short_press_r;
   logic             long_press_r;
   logic             repeat_press_r;
   logic             held_r;

   // Threshold selection: hold threshold while pressed, repeat period while long-held.
   always_comb begin
      if (state_r == S_LONG_HELD) begin
         limit_s = REPEAT_LIM;
      end else begin
         limit_s = LONG_LIM;
      end
   end

   press_timer #(
      .W(CNT_W)
   ) u_press_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_s),
      .load  (load_s),
      .limit (limit_s),
      .hit   (hit_s)
   );

   // Next-state and pulse decode; a release always takes priority over a threshold hit.
   always_comb begin
      state_nxt_s  = state_r;
      short_nxt_s  = 1'b0;
      long_nxt_s   = 1'b0;
      repeat_nxt_s = 1'b0;
      clr_s        = 1'b0;
      load_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (debounced_button) begin
               state_nxt_s = S_PRESSED;
               load_s      = 1'b1;
            end else begin
               clr_s = 1'b1;
            end
         end
         S_PRESSED: begin
            if (!debounced_button) begin
               state_nxt_s = S_IDLE;
               short_nxt_s = 1'b1;
               clr_s       = 1'b1;
            end else if (hit_s) begin
               state_nxt_s = S_LONG_HELD;
               long_nxt_s  = 1'b1;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = S_PRESSED;
            end
         end
         S_LONG_HELD: begin
            if (!debounced_button) begin
               state_nxt_s = S_IDLE;
               clr_s       = 1'b1;
            end else if (hit_s) begin
               repeat_nxt_s = REPEAT_EN;
               load_s       = 1'b1;
            end else begin
               state_nxt_s = S_LONG_HELD;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            clr_s       = 1'b1;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= S_IDLE;
         short_press_r  <= 1'b0;
         long_press_r   <= 1'b0;
         repeat_press_r <= 1'b0;
         held_r         <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         short_press_r  <= short_nxt_s;
         long_press_r   <= long_nxt_s;
         repeat_press_r <= repeat_nxt_s;
         held_r         <= (state_nxt_s != S_IDLE);
      end
   end

   assign short_press  = short_press_r;
   assign long_press   = long_press_r;
   assign repeat_press = repeat_press_r;
   assign held         = held_r;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed plus randomized bench comparing two decoder instances against a press-length model.
`timescale 1ns/100ps
module tb_button_press_decoder;

   localparam int LT = 10;
   localparam int RT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn = 1'b0;
   logic a_short, a_long, a_rep, a_held;
   logic b_short, b_long, b_rep, b_held;

   int checks   = 0;
   int failures = 0;

   bit   pressing = 1'b0;
   int   len      = 0;
   logic e_short  = 1'b0;
   logic e_long   = 1'b0;
   logic e_rep    = 1'b0;
   logic e_held   = 1'b0;

   always #1 clk = ~clk;

   button_press_decoder #(.LONG_TIME(LT), .REPEAT_TIME(RT), .REPEAT_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .debounced_button(btn),
      .short_press(a_short), .long_press(a_long), .repeat_press(a_rep), .held(a_held));

   button_press_decoder #(.LONG_TIME(LT), .REPEAT_TIME(RT), .REPEAT_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .debounced_button(btn),
      .short_press(b_short), .long_press(b_long), .repeat_press(b_rep), .held(b_held));

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ".a_short"}, a_short, e_short);
      chk({where, ".a_long"},  a_long,  e_long);
      chk({where, ".a_rep"},   a_rep,   e_rep);
      chk({where, ".a_held"},  a_held,  e_held);
      chk({where, ".b_short"}, b_short, e_short);
      chk({where, ".b_long"},  b_long,  e_long);
      chk({where, ".b_rep"},   b_rep,   1'b0);
      chk({where, ".b_held"},  b_held,  e_held);
   endtask

   // Model: len counts edges since the press edge E0; pulses follow from len alone.
   task automatic model_edge();
      e_short = 1'b0;
      e_long  = 1'b0;
      e_rep   = 1'b0;
      e_held  = 1'b0;
      if (!rst) begin
         pressing = 1'b0;
         len      = 0;
      end else if (btn) begin
         if (!pressing) begin
            pressing = 1'b1;
            len      = 0;
         end else begin
            len++;
            e_long = (len == LT);
            e_rep  = (len > LT) && (((len - LT) % RT) == 0);
         end
         e_held = 1'b1;
      end else begin
         if (pressing && (len + 1 <= LT)) e_short = 1'b1;
         pressing = 1'b0;
      end
   endtask

   task automatic step(input logic b, input string where);
      btn = b;
      @(posedge clk);
      model_edge();
      #1;
      check_all(where);
   endtask

   task automatic hold(input logic b, input int n, input string where);
      repeat (n) step(b, where);
   endtask

   task automatic async_reset(input string where);
      rst = 1'b0;
      #0.5;
      pressing = 1'b0;
      len      = 0;
      e_short  = 1'b0;
      e_long   = 1'b0;
      e_rep    = 1'b0;
      e_held   = 1'b0;
      check_all(where);
   endtask

   initial begin
      int n;
      logic v;
      // Reset held with the button already pressed.
      btn = 1'b1;
      #0.5;
      check_all("rst_init");
      @(posedge clk);
      #1;
      check_all("rst_edge");
      rst = 1'b1;
      step(1'b1, "first_edge");
      step(1'b0, "min_release");
      step(1'b0, "idle0");
      // Three-sample press.
      hold(1'b1, 3, "short3");
      step(1'b0, "short3_rel");
      hold(1'b0, 2, "short3_idle");
      // Long hold with repeats.
      hold(1'b1, 20, "hold20");
      step(1'b0, "hold20_rel");
      hold(1'b0, 3, "hold20_idle");
      // Release exactly on the long threshold edge.
      hold(1'b1, 10, "e10");
      step(1'b0, "e10_rel");
      step(1'b0, "e10_idle");
      // Long hold, repeats suppressed on dut_b.
      hold(1'b1, 30, "hold30");
      step(1'b0, "hold30_rel");
      // Re-press immediately after a release.
      step(1'b1, "repress0");
      step(1'b0, "repress1");
      step(1'b1, "repress2");
      step(1'b0, "repress3");
      step(1'b0, "repress4");
      // Reset while long-held.
      hold(1'b1, 15, "pre_rst");
      async_reset("rst_long");
      step(1'b0, "rst_release");
      rst = 1'b1;
      step(1'b0, "post_rst_idle");
      hold(1'b1, 12, "post_rst_hold");
      step(1'b0, "post_rst_rel");
      // Randomized runs of presses and releases with occasional resets.
      v = 1'b0;
      for (int i = 0; i < 300; i++) begin
         v = ~v;
         n = $urandom_range(1, 25);
         if ($urandom_range(0, 19) == 0) begin
            async_reset("rnd_rst");
            step(v, "rnd_in_rst");
            rst = 1'b1;
         end
         hold(v, n, "rnd");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
